// File: rtl/draw_pipes_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_if
// Description : VGA pixel stream bundle (timing counters, syncs, blanks, RGB).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_pipes.sv
`default_nettype none
// ============================================================================
// Module      : draw_pipes
// Description : Overlays scrolling pipe obstacles on the background VGA stream,
//               runs the game-state FSM, gap LFSR and score counter.
//               Optional macro PIPE_CAP_EN: darker caps on the 16 rows that
//               border each gap.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_pipes #(
    parameter int          NUM_PIPES    = 3,
    parameter int          PIPE_W       = 80,
    parameter int          PIPE_SPACING = 400,
    parameter int          X_START      = 1024,
    parameter int          SPEED        = 4,
    parameter int          GAP_H        = 200,
    parameter int          GAP_MIN      = 150,
    parameter int          GROUND_Y     = 675,
    parameter logic [11:0] PIPE_RGB     = 12'h0A0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    vga_if.in          vin,
    vga_if.out         vout,
    output logic [7:0] score,
    output logic       running
);

    localparam logic [11:0] c_speed    = 12'(SPEED);
    localparam logic [11:0] c_wrap_add = 12'(NUM_PIPES * PIPE_SPACING - SPEED);
    localparam logic [10:0] c_gap_init = 11'(GAP_MIN + 100);
    localparam logic [10:0] c_gap_min  = 11'(GAP_MIN);
    localparam logic [12:0] c_pipe_w   = 13'(PIPE_W);
    localparam logic [11:0] c_gap_h    = 12'(GAP_H);
    localparam logic [10:0] c_ground_y = 11'(GROUND_Y);
`ifdef PIPE_CAP_EN
    localparam logic [11:0] c_cap_rgb  = 12'h060;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_reload;
    logic        w_move;
    logic        w_tick;
    logic        r_vblnk_prev;
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;
    logic [11:0] r_x   [NUM_PIPES];
    logic [10:0] r_gap [NUM_PIPES];
    logic [7:0]  w_wrap_cnt;
    logic [8:0]  w_score_sum;

    logic [NUM_PIPES-1:0] w_in_col;
    logic [NUM_PIPES-1:0] w_out_gap;
    logic                 w_draw;
    logic [11:0]          w_pipe_rgb;
`ifdef PIPE_CAP_EN
    logic [NUM_PIPES-1:0] w_in_cap;
`endif

    assign w_tick    = vin.vblnk & ~r_vblnk_prev;
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // ------------------------------------------------------------------
    // Game-state FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            running <= 1'b0;
        end else begin
            r_state <= w_state_next;
            running <= (w_state_next == ST_RUN);
        end
    end

    // Hit has priority over start in RUN; a start cycle never also moves pipes.
    always_comb begin
        w_state_next = r_state;
        w_reload     = 1'b0;
        w_move       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_reload     = 1'b1;
                end
            end
            ST_RUN: begin
                if (hit) begin
                    w_state_next = ST_DEAD;
                end else if (w_tick) begin
                    w_move = 1'b1;
                end
            end
            ST_DEAD: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_reload     = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // LFSR and frame-edge detector
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr       <= 16'hACE1;
            r_vblnk_prev <= 1'b0;
        end else begin
            r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
            r_vblnk_prev <= vin.vblnk;
        end
    end

    // ------------------------------------------------------------------
    // Pipe positions, gaps and score
    // ------------------------------------------------------------------
    always_comb begin
        w_wrap_cnt = 8'd0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (r_x[i] < c_speed) begin
                w_wrap_cnt = w_wrap_cnt + 8'd1;
            end
        end
    end

    assign w_score_sum = {1'b0, score} + {1'b0, w_wrap_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_x[i]   <= 12'(X_START + i * PIPE_SPACING);
                r_gap[i] <= c_gap_init;
            end
            score <= 8'd0;
        end else if (w_reload) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_x[i]   <= 12'(X_START + i * PIPE_SPACING);
                r_gap[i] <= c_gap_init;
            end
            score <= 8'd0;
        end else if (w_move) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (r_x[i] < c_speed) begin
                    r_x[i]   <= r_x[i] + c_wrap_add;
                    r_gap[i] <= c_gap_min + {3'b000, r_lfsr[7:0]};
                end else begin
                    r_x[i]   <= r_x[i] - c_speed;
                end
            end
            score <= w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Per-pipe pixel hit test
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
            logic [11:0] w_gap_end;
            assign w_gap_end     = {1'b0, r_gap[gi]} + c_gap_h;
            assign w_in_col[gi]  = ({1'b0, vin.hcount} >= r_x[gi]) &&
                                   ({2'b00, vin.hcount} < ({1'b0, r_x[gi]} + c_pipe_w));
            assign w_out_gap[gi] = (vin.vcount < r_gap[gi]) ||
                                   ({1'b0, vin.vcount} >= w_gap_end);
`ifdef PIPE_CAP_EN
            assign w_in_cap[gi]  = ((vin.vcount >= (r_gap[gi] - 11'd16)) &&
                                    (vin.vcount < r_gap[gi])) ||
                                   (({1'b0, vin.vcount} >= w_gap_end) &&
                                    ({1'b0, vin.vcount} < (w_gap_end + 12'd16)));
`endif
        end
    endgenerate

    assign w_draw = (r_state != ST_IDLE) && !vin.vblnk && !vin.hblnk &&
                    (vin.vcount <= c_ground_y) && |(w_in_col & w_out_gap);

`ifdef PIPE_CAP_EN
    assign w_pipe_rgb = |(w_in_col & w_out_gap & w_in_cap) ? c_cap_rgb : PIPE_RGB;
`else
    assign w_pipe_rgb = PIPE_RGB;
`endif

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vout.vcount <= 11'd0;
            vout.hcount <= 11'd0;
            vout.vsync  <= 1'b0;
            vout.hsync  <= 1'b0;
            vout.vblnk  <= 1'b0;
            vout.hblnk  <= 1'b0;
            vout.rgb    <= 12'd0;
        end else begin
            vout.vcount <= vin.vcount;
            vout.hcount <= vin.hcount;
            vout.vsync  <= vin.vsync;
            vout.hsync  <= vin.hsync;
            vout.vblnk  <= vin.vblnk;
            vout.hblnk  <= vin.hblnk;
            vout.rgb    <= w_draw ? w_pipe_rgb : vin.rgb;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_pipes.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_pipes
// Description : Scoreboard bench for draw_pipes; honours PIPE_CAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_pipes;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic hit = 1'b0;
    logic [7:0] score;
    logic running;

    vga_if vin_if ();
    vga_if vout_if ();

    draw_pipes dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .hit     (hit),
        .vin     (vin_if),
        .vout    (vout_if),
        .score   (score),
        .running (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic [10:0] h;
        logic [10:0] v;
        logic [3:0]  tim;
        logic [7:0]  score;
        logic        running;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the game state
    int          m_state;
    int          m_x   [3];
    int          m_gap [3];
    int          m_score;
    logic [15:0] m_lfsr;
    logic        m_prev;

    function automatic void model_reset();
        m_state = 0;
        for (int i = 0; i < 3; i++) begin
            m_x[i]   = 1024 + i * 400;
            m_gap[i] = 250;
        end
        m_score = 0;
        m_lfsr  = 16'hACE1;
        m_prev  = 1'b0;
    endfunction

    function automatic logic [11:0] exp_rgb(int h, int v, logic [11:0] c, logic vb, logic hb);
        logic [11:0] r = c;
        if (m_state != 0 && !vb && !hb && v <= 675) begin
            for (int i = 0; i < 3; i++) begin
                if (h >= m_x[i] && h < m_x[i] + 80 && (v < m_gap[i] || v >= m_gap[i] + 200)) begin
                    r = 12'h0A0;
`ifdef PIPE_CAP_EN
                    if ((v >= m_gap[i] - 16 && v < m_gap[i]) ||
                        (v >= m_gap[i] + 200 && v < m_gap[i] + 216))
                        r = 12'h060;
`endif
                end
            end
        end
        return r;
    endfunction

    function automatic void model_step(logic st, logic ht, logic vb);
        logic tick = vb && !m_prev;
        int wraps = 0;
        case (m_state)
            0, 2: if (st) begin
                m_state = 1;
                for (int i = 0; i < 3; i++) begin
                    m_x[i]   = 1024 + i * 400;
                    m_gap[i] = 250;
                end
                m_score = 0;
            end
            default: begin
                if (ht) m_state = 2;
                else if (tick) begin
                    for (int i = 0; i < 3; i++) begin
                        if (m_x[i] < 4) begin
                            m_x[i]   = m_x[i] + 1196;
                            m_gap[i] = 150 + int'(m_lfsr[7:0]);
                            wraps++;
                        end else begin
                            m_x[i] = m_x[i] - 4;
                        end
                    end
                    m_score = (m_score + wraps > 255) ? 255 : m_score + wraps;
                end
            end
        endcase
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_prev = vb;
    endfunction

    // Drive one pixel cycle and push the expected registered output
    task automatic cycle(input logic r, input logic st, input logic ht, input logic vb,
                         input logic hb, input int h, input int v, input logic [11:0] c);
        exp_t e;
        logic vs;
        logic hs;
        @(negedge clk);
        vs = 1'($urandom_range(0, 1));
        hs = 1'($urandom_range(0, 1));
        rst = r; start = st; hit = ht;
        vin_if.hcount = 11'(h); vin_if.vcount = 11'(v);
        vin_if.vsync = vs; vin_if.hsync = hs;
        vin_if.vblnk = vb; vin_if.hblnk = hb; vin_if.rgb = c;
        if (r) begin
            model_reset();
            e = '{rgb: 12'd0, h: 11'd0, v: 11'd0, tim: 4'd0, score: 8'd0, running: 1'b0};
        end else begin
            e.rgb = exp_rgb(h, v, c, vb, hb);
            e.h = 11'(h); e.v = 11'(v); e.tim = {vs, hs, vb, hb};
            model_step(st, ht, vb);
            e.score = 8'(m_score);
            e.running = (m_state == 1);
        end
        q.push_back(e);
    endtask

    task automatic tick();
        cycle(0, 0, 0, 1, 0, $urandom_range(0, 1279), $urandom_range(0, 767), 12'($urandom));
        cycle(0, 0, 0, 0, ($urandom_range(0, 7) == 0), $urandom_range(0, 1279),
              $urandom_range(0, 767), 12'($urandom));
    endtask

    task automatic pix(input int h, input int v, input logic [11:0] c);
        cycle(0, 0, 0, 0, 0, h, v, c);
        @(posedge clk); #2;
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            n_checks += 4;
            if (vout_if.rgb !== me.rgb) begin
                n_errors++;
                $display("FAIL sb_rgb got %h exp %h (h=%0d v=%0d)", vout_if.rgb, me.rgb, me.h, me.v);
            end
            if ({vout_if.hcount, vout_if.vcount, vout_if.vsync, vout_if.hsync, vout_if.vblnk, vout_if.hblnk}
                !== {me.h, me.v, me.tim}) begin
                n_errors++;
                $display("FAIL sb_timing got %h/%h exp %h/%h", vout_if.hcount, vout_if.vcount, me.h, me.v);
            end
            if (score !== me.score) begin
                n_errors++;
                $display("FAIL sb_score got %0d exp %0d", score, me.score);
            end
            if (running !== me.running) begin
                n_errors++;
                $display("FAIL sb_running got %b exp %b", running, me.running);
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 100 + i, 50, 12'hFFF);
        @(posedge clk); #2;
        n_checks++;
        if ({vout_if.rgb, vout_if.hcount, vout_if.vcount, score, running} !== '0) begin
            n_errors++;
            $display("FAIL reset_zero got rgb %h h %0d score %0d", vout_if.rgb, vout_if.hcount, score);
        end
        cycle(0, 0, 0, 0, 0, 321, 10, 12'h111);
        @(posedge clk); #2;
        n_checks++;
        if (vout_if.hcount !== 11'd321) begin
            n_errors++;
            $display("FAIL release_hcount got %0d exp 321", vout_if.hcount);
        end
        pix(1030, 100, 12'h5A5);
        n_checks++;
        if (vout_if.rgb !== 12'h5A5) begin
            n_errors++;
            $display("FAIL idle_nopipe got %h exp 5a5", vout_if.rgb);
        end
        // Enter RUN, then reset in the middle of the stream
        cycle(0, 1, 0, 0, 0, 10, 10, 12'h222);
        for (int i = 0; i < 4; i++) tick();
        cycle(1, 0, 0, 0, 0, 1030, 100, 12'h333);
        @(posedge clk); #2;
        n_checks++;
        if ({vout_if.rgb, vout_if.hcount, score, running} !== '0) begin
            n_errors++;
            $display("FAIL midreset_zero got rgb %h running %b", vout_if.rgb, running);
        end
        pix(1030, 100, 12'h444);
        n_checks++;
        if (vout_if.rgb !== 12'h444 || running !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_idle got %h/%b exp 444/0", vout_if.rgb, running);
        end
    endtask

    task automatic test_run();
        cycle(0, 1, 0, 0, 0, 0, 0, 12'h000);
        for (int i = 0; i < 10; i++) tick();
        pix(1000, 100, 12'h123);
        n_checks++;
        if (vout_if.rgb !== 12'h0A0) begin
            n_errors++; $display("FAIL pipe_body got %h exp 0a0", vout_if.rgb);
        end
        pix(1000, 300, 12'h123);
        n_checks++;
        if (vout_if.rgb !== 12'h123) begin
            n_errors++; $display("FAIL pipe_gap got %h exp 123", vout_if.rgb);
        end
        pix(1000, 690, 12'h123);
        n_checks++;
        if (vout_if.rgb !== 12'h123) begin
            n_errors++; $display("FAIL below_ground got %h exp 123", vout_if.rgb);
        end
        pix(1063, 675, 12'h123);
        n_checks++;
        if (vout_if.rgb !== 12'h0A0) begin
            n_errors++; $display("FAIL edge_ground got %h exp 0a0", vout_if.rgb);
        end
        pix(1064, 100, 12'h123);
        n_checks++;
        if (vout_if.rgb !== 12'h123) begin
            n_errors++; $display("FAIL right_edge got %h exp 123", vout_if.rgb);
        end
        pix(1000, 240, 12'h123);
        n_checks++;
`ifdef PIPE_CAP_EN
        if (vout_if.rgb !== 12'h060) begin
            n_errors++; $display("FAIL cap_top got %h exp 060", vout_if.rgb);
        end
`else
        if (vout_if.rgb !== 12'h0A0) begin
            n_errors++; $display("FAIL cap_top got %h exp 0a0", vout_if.rgb);
        end
`endif
        pix(1000, 233, 12'h123);
        n_checks++;
        if (vout_if.rgb !== 12'h0A0) begin
            n_errors++; $display("FAIL above_cap got %h exp 0a0", vout_if.rgb);
        end
        cycle(0, 0, 0, 0, 1, 1000, 100, 12'h456);
        @(posedge clk); #2;
        n_checks++;
        if (vout_if.rgb !== 12'h456) begin
            n_errors++; $display("FAIL blank_pass got %h exp 456", vout_if.rgb);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 400 && m_x[0] != 0; i++) tick();
        @(posedge clk); #2;
        n_checks++;
        if (score !== 8'd0) begin
            n_errors++; $display("FAIL prewrap_score got %0d exp 0", score);
        end
        tick();
        @(posedge clk); #2;
        n_checks++;
        if (score !== 8'd1) begin
            n_errors++; $display("FAIL wrap_score got %0d exp 1", score);
        end
        pix(1196, 0, 12'h777);
        n_checks++;
        if (vout_if.rgb !== 12'h0A0) begin
            n_errors++; $display("FAIL wrap_left got %h exp 0a0", vout_if.rgb);
        end
        pix(1195, 0, 12'h777);
        n_checks++;
        if (vout_if.rgb !== 12'h777) begin
            n_errors++; $display("FAIL wrap_outside got %h exp 777", vout_if.rgb);
        end
        pix(1200, 149, 12'h777);
        n_checks++;
        if (vout_if.rgb === 12'h777) begin
            n_errors++; $display("FAIL gap_low_bound got %h exp pipe", vout_if.rgb);
        end
        pix(1200, 606, 12'h777);
        n_checks++;
        if (vout_if.rgb === 12'h777) begin
            n_errors++; $display("FAIL gap_high_bound got %h exp pipe", vout_if.rgb);
        end
    endtask

    task automatic test_hit();
        cycle(0, 0, 1, 0, 0, 0, 0, 12'h000);
        for (int i = 0; i < 5; i++) tick();
        pix(1196, 0, 12'h777);
        n_checks++;
        if (vout_if.rgb !== 12'h0A0 || running !== 1'b0 || score !== 8'd1) begin
            n_errors++;
            $display("FAIL dead_frozen got %h/%b/%0d exp 0a0/0/1", vout_if.rgb, running, score);
        end
        cycle(0, 1, 0, 0, 0, 0, 0, 12'h000);
        @(posedge clk); #2;
        n_checks++;
        if (running !== 1'b1 || score !== 8'd0) begin
            n_errors++; $display("FAIL restart got %b/%0d exp 1/0", running, score);
        end
        pix(1024, 0, 12'h777);
        n_checks++;
        if (vout_if.rgb !== 12'h0A0) begin
            n_errors++; $display("FAIL reload_x got %h exp 0a0", vout_if.rgb);
        end
        pix(1023, 0, 12'h777);
        n_checks++;
        if (vout_if.rgb !== 12'h777) begin
            n_errors++; $display("FAIL reload_left got %h exp 777", vout_if.rgb);
        end
    endtask

    task automatic test_simultaneous();
        cycle(0, 0, 1, 1, 0, 0, 0, 12'h000);   // hit on a frame tick
        cycle(0, 0, 0, 0, 0, 0, 0, 12'h000);
        pix(1020, 0, 12'h777);
        n_checks++;
        if (vout_if.rgb !== 12'h777 || running !== 1'b0) begin
            n_errors++; $display("FAIL hit_on_tick got %h/%b exp 777/0", vout_if.rgb, running);
        end
        cycle(0, 1, 0, 0, 0, 0, 0, 12'h000);
        cycle(0, 1, 1, 0, 0, 0, 0, 12'h000);   // hit and start together
        @(posedge clk); #2;
        n_checks++;
        if (running !== 1'b0) begin
            n_errors++; $display("FAIL hit_start_same got %b exp 0", running);
        end
        cycle(0, 1, 0, 1, 0, 0, 0, 12'h000);   // start on a frame tick
        cycle(0, 0, 0, 0, 0, 0, 0, 12'h000);
        pix(1024, 0, 12'h777);
        n_checks++;
        if (vout_if.rgb !== 12'h0A0 || running !== 1'b1) begin
            n_errors++; $display("FAIL start_on_tick got %h/%b exp 0a0/1", vout_if.rgb, running);
        end
    endtask

    task automatic test_saturation();
        cycle(0, 0, 1, 0, 0, 0, 0, 12'h000);
        cycle(0, 1, 0, 0, 0, 0, 0, 12'h000);
        for (int i = 0; i < 25760; i++) tick();
        @(posedge clk); #2;
        n_checks++;
        if (score !== 8'd255) begin
            n_errors++; $display("FAIL score_saturate got %0d exp 255", score);
        end
    endtask

    initial begin
        model_reset();
        vin_if.hcount = '0; vin_if.vcount = '0; vin_if.vsync = 1'b0; vin_if.hsync = 1'b0;
        vin_if.vblnk = 1'b0; vin_if.hblnk = 1'b0; vin_if.rgb = '0;
        test_reset();
        test_run();
        test_wrap();
        test_hit();
        test_simultaneous();
        test_saturation();
        cycle(0, 0, 0, 0, 0, 0, 0, 12'h000);
        cycle(0, 0, 0, 0, 0, 0, 0, 12'h000);
        @(posedge clk); #3;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++; $display("FAIL sb_drain got %0d entries exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
